// File: rtl/digit_serial_subtractor_pkg.sv
// ============================================================================
// dss_pkg : shared types and helpers for the digit-serial subtractor
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package dss_pkg;

  localparam int c_MAX_DIGIT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dss_state_e;

  function automatic bit dss_cfg_ok(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && (digit <= width) &&
           (digit <= c_MAX_DIGIT) && ((width % digit) == 0);
  endfunction

  // {borrow, diff} of a - b - bin; bits above the live digit all replicate the borrow
  function automatic logic [c_MAX_DIGIT:0] dss_digit_sub(
    input logic [c_MAX_DIGIT-1:0] a,
    input logic [c_MAX_DIGIT-1:0] b,
    input logic                   bin
  );
    return {1'b0, a} - {1'b0, b} - {{c_MAX_DIGIT{1'b0}}, bin};
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_serial_subtractor_cell.sv
// ============================================================================
// digit_sub_cell : combinational DIGIT-bit subtractor with borrow in/out
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module digit_sub_cell
  import dss_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [c_MAX_DIGIT:0] w_res;

  assign w_res = dss_digit_sub(c_MAX_DIGIT'(a), c_MAX_DIGIT'(b), bin);
  assign d     = w_res[DIGIT-1:0];
  // every bit above the digit is a sign copy, so any of them is the borrow
  assign bo    = &w_res[c_MAX_DIGIT:DIGIT];

endmodule

`default_nettype wire

// File: rtl/digit_serial_subtractor.sv
// ============================================================================
// digit_serial_subtractor : a - b - borrow_in, DIGIT bits/clock, LSB first.
// Option macro DSS_SATURATE_EN clamps diff to 0 when the final borrow is set.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module digit_serial_subtractor
  import dss_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int NUM_DIGITS            = WIDTH / DIGIT;
  localparam int c_CW                  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_CW-1:0] c_LAST   = c_CW'(NUM_DIGITS - 1);

  generate
    if (!dss_cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
      $error("digit_serial_subtractor: WIDTH must be a multiple of DIGIT (1..64)");
    end
  endgenerate

  dss_state_e       r_state;
  dss_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic             r_borrow;
  logic [c_CW-1:0]  r_cnt;
  logic [DIGIT-1:0] w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == c_LAST);

  digit_sub_cell #(.DIGIT(DIGIT)) u_cell (
    .a   (r_a[DIGIT-1:0]),
    .b   (r_b[DIGIT-1:0]),
    .bin (r_borrow),
    .d   (w_d),
    .bo  (w_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // new digit enters at the top so digit 0 lands at the bottom after the last shift
  always_comb begin
    w_result_nxt = (r_result >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));
`ifdef DSS_SATURATE_EN
    if (w_last && w_bo) w_result_nxt = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= borrow_in;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_borrow <= w_bo;
      r_cnt    <= r_cnt + 1'b1;
      r_result <= w_result_nxt;
    end
  end

  assign diff       = r_result;
  assign borrow_out = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_subtractor.sv
// ============================================================================
// tb_digit_serial_subtractor : randomized + directed bench with arithmetic model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_digit_serial_subtractor;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, borrow_in, out_valid, out_ready, borrow_out, busy;
  logic [W-1:0]  a, b, diff;
  logic          a1, b1, bi1, iv1, ir1, ov1, or1, d1, bo1, busy1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  digit_serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out), .busy(busy)
  );

  digit_serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .borrow_in(bi1), .out_valid(ov1),
    .out_ready(or1), .diff(d1), .borrow_out(bo1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {borrow, diff} from plain integer arithmetic
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    int         t;
    logic       brw;
    logic [W-1:0] r;
    t   = int'(x) - int'(y) - int'(bi);
    brw = (t < 0);
    r   = t[W-1:0];
`ifdef DSS_SATURATE_EN
    if (brw) r = '0;
`endif
    return {brw, r};
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                       input int stall, input string tag);
    logic [W:0] e;
    int         lat;
    e   = ref_sub(x, y, bi);
    lat = 0;
    while (!in_ready && lat < 50) begin @(negedge clk); lat++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    out_ready = (stall == 0);
    a = x; b = y; borrow_in = bi; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_diff"}, diff, e[W-1:0]);
    chk({tag, "_borrow"}, borrow_out, e[W]);
    chk({tag, "_busy_done"}, busy, 1);
    if (stall > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        a = W'($urandom); b = W'($urandom);
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_diff"}, diff, e[W-1:0]);
        chk({tag, "_hold_borrow"}, borrow_out, e[W]);
        chk({tag, "_hold_in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_in_ready"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  task automatic do_op1(input logic x, input logic y, input logic bi);
    int   t;
    int   lat;
    logic ed;
    logic eb;
    t  = int'(x) - int'(y) - int'(bi);
    eb = (t < 0);
    ed = t[0];
`ifdef DSS_SATURATE_EN
    if (eb) ed = 1'b0;
`endif
    or1 = 1'b1;
    a1 = x; b1 = y; bi1 = bi; iv1 = 1'b1;
    chk("w1_in_ready", ir1, 1);
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 50) begin @(negedge clk); lat++; end
    chk("w1_latency", lat, 1);
    chk("w1_diff", d1, ed);
    chk("w1_borrow", bo1, eb);
    @(negedge clk);
    chk("w1_post_valid", ov1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rx, ry;
    bit           early;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    iv1 = 1'b0; or1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h0234, 1'b0, 0, "tp1");
    do_op(16'h0000, 16'h0001, 1'b0, 0, "tp2");
    do_op(16'h0005, 16'h0005, 1'b1, 5, "tp3_bp");
    do_op(16'hFFFF, 16'h0000, 1'b1, 0, "max_bin");
    do_op(16'h0000, 16'hFFFF, 1'b1, 0, "min_max");
    do_op(16'h8000, 16'h8000, 1'b0, 1, "equal");

    // abort mid-RUN
    a = 16'hABCD; b = 16'h1234; borrow_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_diff", diff, 0);
    chk("arst_borrow", borrow_out, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    early = 1'b0;
    repeat (N + 2) begin
      @(negedge clk);
      if (out_valid) early = 1'b1;
    end
    chk("arst_no_result", early, 0);
    do_op(16'h00FF, 16'h000F, 1'b0, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      rx = W'($urandom);
      ry = (i % 5 == 0) ? rx : W'($urandom);
      do_op(rx, ry, 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      do_op1(v[2], v[1], v[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
